// File: rtl/spi_byte_engine.sv
// Byte-wide SPI mode-0 master shifter with a one-entry transmit holding register.
// Shifts MSB first on MOSI while capturing MISO and returns each received byte with a valid pulse.
module spi_byte_engine (
    input  logic       iClk,
    input  logic       iRstN,
    input  logic [3:0] iClkDiv,
    input  logic       iSend,
    input  logic [7:0] iData,
    output logic [7:0] oData,
    output logic       oAvail,
    output logic       oTaken,
    output logic       oBusy,
    output logic       oMosi,
    input  logic       iMiso,
    output logic       oSck
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DIV_W  = 4;
    localparam int unsigned BIT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                avail_q, avail_d;
    logic                taken_q, taken_d;
    logic                busy_q, busy_d;

    logic phase_done;
    logic last_bit;
    logic load;
    logic accept;

    assign phase_done = (cnt_q == '0);
    assign last_bit   = (bit_cnt_q == '0);
    // Hold moves into the shifter from idle, or seamlessly at the end of the last high phase.
    assign load   = hold_full_q &&
                    ((state_q == ST_IDLE) ||
                     ((state_q == ST_HI) && phase_done && last_bit));
    assign accept = iSend && (!hold_full_q || load);

    // State register
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (phase_done) begin
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                if (phase_done) begin
                    if (!last_bit || hold_full_q) begin
                        state_d = ST_LO;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        rx_d        = rx_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        data_d      = data_q;
        avail_d     = 1'b0;
        taken_d     = 1'b0;

        if ((state_q != ST_IDLE) && !phase_done) begin
            cnt_d = cnt_q - DIV_W'(1);
        end

        if ((state_q == ST_LO) && phase_done) begin
            cnt_d = div_q;
            sck_d = 1'b1;
            rx_d  = {rx_q[DATA_W-2:0], iMiso};
        end

        if ((state_q == ST_HI) && phase_done) begin
            sck_d = 1'b0;
            if (!last_bit) begin
                cnt_d     = div_q;
                bit_cnt_d = bit_cnt_q - BIT_W'(1);
                shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                mosi_d    = shift_q[DATA_W-2];
            end else begin
                data_d  = rx_q;
                avail_d = 1'b1;
                mosi_d  = 1'b1;
            end
        end

        if (load) begin
            shift_d   = hold_q;
            div_d     = iClkDiv;
            cnt_d     = iClkDiv;
            bit_cnt_d = BIT_W'(DATA_W - 1);
            mosi_d    = hold_q[DATA_W-1];
            taken_d   = 1'b1;
        end

        hold_full_d = accept || (hold_full_q && !load);
        if (accept) begin
            hold_d = iData;
        end

        // Includes the current state so busy stays up through the completion cycle.
        busy_d = (state_d != ST_IDLE) || hold_full_d || (state_q != ST_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            rx_q        <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b1;
            data_q      <= '0;
            avail_q     <= 1'b0;
            taken_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            rx_q        <= rx_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            data_q      <= data_d;
            avail_q     <= avail_d;
            taken_q     <= taken_d;
            busy_q      <= busy_d;
        end
    end

    assign oData  = data_q;
    assign oAvail = avail_q;
    assign oTaken = taken_q;
    assign oBusy  = busy_q;
    assign oMosi  = mosi_q;
    assign oSck   = sck_q;

endmodule
